// File: rtl/fp_pkg.sv
// Shared constants, op encodings and FSM states for the int32 <-> float32 converter.
package fp_pkg;

  localparam int          EXP_BIAS    = 127;
  localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;
  localparam logic [31:0] INT_MAX     = 32'h7FFFFFFF;
  localparam logic [31:0] INT_MIN     = 32'h80000000;
  localparam logic [31:0] FP_NEG_2P31 = 32'hCF000000;

  typedef enum logic {
    CVT_S_W   = 1'b0,
    TRUNC_W_S = 1'b1
  } cvt_op_e;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    SHIFT,
    PACK,
    DONE
  } state_e;

endpackage

// File: rtl/fp_convert_unit_lzc32.sv
// Combinational 32-bit leading-zero counter; returns 32 for an all-zero input.
module lzc32 (
  input  logic [31:0] value,
  output logic [5:0]  count
);

  // Scanning upward lets the highest set bit overwrite any lower hit.
  always_comb begin
    count = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (value[i]) count = 6'(31 - i);
    end
  end

endmodule

// File: rtl/fp_convert_unit.sv
// Multi-cycle cvt.s.w / trunc.w.s converter with a start/done handshake.
// Optional FPCVT_INEXACT_EN adds the f_inexact output and its sticky tracking.
module fp_convert_unit
  import fp_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        f_cvt_op,
  input  logic [31:0] f_input,
  output logic [31:0] f_output,
  output logic        busy,
  output logic        done,
  output logic        f_invalid
`ifdef FPCVT_INEXACT_EN
  ,
  output logic        f_inexact
`endif
);

  localparam logic [7:0] BIAS8   = 8'(EXP_BIAS);
  localparam logic [7:0] EXP_TOP = 8'(EXP_BIAS + 31);
  localparam logic [5:0] STEP6   = 6'(SHIFT_STEP);

  state_e      state;
  cvt_op_e     op_r;
  logic [31:0] in_r, shreg, mag_in, float_res, int_res, spec_val;
  logic [7:0]  exp_r, in_exp;
  logic [5:0]  remaining, lz, amt;
  logic [22:0] frac_rnd;
  logic        sign_r, round_up, frac_carry, spec_hit, spec_inv;
`ifdef FPCVT_INEXACT_EN
  logic        sticky_r, spec_inx;
  logic [31:0] shift_mask;
`endif

  assign in_exp   = in_r[30:23];
  assign mag_in   = in_r[31] ? (~in_r + 32'd1) : in_r;
  assign amt      = (remaining > STEP6) ? STEP6 : remaining;

  lzc32 u_lzc (
    .value (mag_in),
    .count (lz)
  );

  // The hidden bit is always set after normalisation, so a carry out of the
  // 23-bit fraction is the full mantissa overflow and bumps the exponent.
  assign round_up               = shreg[7] & ((|shreg[6:0]) | shreg[8]);
  assign {frac_carry, frac_rnd} = {1'b0, shreg[30:8]} + 24'(round_up);
  assign float_res              = {sign_r, exp_r + {7'd0, frac_carry}, frac_rnd};
  assign int_res                = sign_r ? (~shreg + 32'd1) : shreg;

  always_comb begin
    spec_hit = 1'b0;
    spec_val = '0;
    spec_inv = 1'b0;
`ifdef FPCVT_INEXACT_EN
    spec_inx = 1'b0;
`endif
    if (op_r == CVT_S_W) begin
      spec_hit = (in_r == '0);
    end else if (in_exp == FP_EXP_MAX) begin
      spec_hit = 1'b1;
      spec_val = INT_MAX;
      spec_inv = 1'b1;
    end else if (in_exp < BIAS8) begin
      spec_hit = 1'b1;
`ifdef FPCVT_INEXACT_EN
      spec_inx = |in_r[30:0];
`endif
    end else if (in_exp >= EXP_TOP) begin
      spec_hit = 1'b1;
      if (in_r == FP_NEG_2P31) begin
        spec_val = INT_MIN;
      end else begin
        spec_val = in_r[31] ? INT_MIN : INT_MAX;
        spec_inv = 1'b1;
      end
    end
  end

`ifdef FPCVT_INEXACT_EN
  assign shift_mask = (32'd1 << amt) - 32'd1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_r      <= CVT_S_W;
      in_r      <= '0;
      shreg     <= '0;
      remaining <= '0;
      exp_r     <= '0;
      sign_r    <= 1'b0;
      f_output  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      f_invalid <= 1'b0;
`ifdef FPCVT_INEXACT_EN
      f_inexact <= 1'b0;
      sticky_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= cvt_op_e'(f_cvt_op);
            in_r  <= f_input;
            busy  <= 1'b1;
            state <= UNPACK;
          end
        end
        UNPACK: begin
          sign_r <= in_r[31];
          exp_r  <= EXP_TOP;
`ifdef FPCVT_INEXACT_EN
          sticky_r <= 1'b0;
`endif
          if (op_r == CVT_S_W) begin
            shreg     <= mag_in;
            remaining <= lz;
          end else begin
            shreg     <= {1'b1, in_r[22:0], 8'd0};
            remaining <= 6'(EXP_TOP - in_exp);
          end
          if (spec_hit) begin
            f_output  <= spec_val;
            f_invalid <= spec_inv;
`ifdef FPCVT_INEXACT_EN
            f_inexact <= spec_inx;
`endif
            done  <= 1'b1;
            state <= DONE;
          end else if (op_r == CVT_S_W && lz == 6'd0) begin
            state <= PACK;
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          shreg     <= (op_r == CVT_S_W) ? (shreg << amt) : (shreg >> amt);
          exp_r     <= exp_r - {2'b00, amt};
          remaining <= remaining - amt;
`ifdef FPCVT_INEXACT_EN
          if (op_r == TRUNC_W_S) sticky_r <= sticky_r | (|(shreg & shift_mask));
`endif
          if (remaining == amt) state <= PACK;
        end
        PACK: begin
          f_output  <= (op_r == CVT_S_W) ? float_res : int_res;
          f_invalid <= 1'b0;
`ifdef FPCVT_INEXACT_EN
          f_inexact <= (op_r == CVT_S_W) ? (shreg[7] | (|shreg[6:0])) : sticky_r;
`endif
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_convert_unit.sv
// Self-checking bench for fp_convert_unit: directed table, randomized model checks,
// start-while-busy and mid-operation reset sequences.
module tb_fp_convert_unit;

  localparam int STEP = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        f_cvt_op = 1'b0;
  logic [31:0] f_input = '0;
  logic [31:0] f_output;
  logic        busy, done, f_invalid;
`ifdef FPCVT_INEXACT_EN
  logic        f_inexact;
`endif

  int checks = 0;
  int failures = 0;

  fp_convert_unit #(.SHIFT_STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .f_cvt_op  (f_cvt_op),
    .f_input   (f_input),
    .f_output  (f_output),
    .busy      (busy),
    .done      (done),
    .f_invalid (f_invalid)
`ifdef FPCVT_INEXACT_EN
    ,
    .f_inexact (f_inexact)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        op;
    logic [31:0] in;
    logic [31:0] want;
    logic        inv;
    logic        inx;
    int          cyc;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got=0x%08h want=0x%08h", name, got, want);
    end
  endtask

  // Reference model built from the numeric definition of the conversions.
  task automatic refModel(input logic op, input logic [31:0] x, output logic [31:0] r,
                          output logic inv, output logic inx, output int cyc);
    logic [63:0] m, q, rem, half;
    logic [31:0] v, m32;
    int p, sc, e, k;
    r = '0; inv = 1'b0; inx = 1'b0; cyc = 2;
    if (op == 1'b0) begin
      if (x != 32'd0) begin
        m = x[31] ? (64'h1_0000_0000 - {32'd0, x}) : {32'd0, x};
        p = 0;
        while ((m >> (p + 1)) != 64'd0) p++;
        e = 127 + p;
        if (p > 23) begin
          sc = p - 23;
          q = m >> sc;
          rem = m - (q << sc);
          half = 64'd1 << (sc - 1);
          if (rem > half || (rem == half && q[0])) q = q + 64'd1;
          inx = (rem != 64'd0);
        end else begin
          q = m << (23 - p);
        end
        if (q == (64'd1 << 24)) begin
          q = 64'd1 << 23;
          e++;
        end
        r = {x[31], 8'(e), q[22:0]};
        k = 31 - p;
        cyc = (k + STEP - 1) / STEP + 3;
      end
    end else begin
      e = int'(x[30:23]);
      if (e == 255) begin
        r = 32'h7FFFFFFF; inv = 1'b1;
      end else if (e < 127) begin
        inx = (x[30:0] != 31'd0);
      end else if (e >= 158) begin
        if (x == 32'hCF000000) r = 32'h80000000;
        else begin
          r = x[31] ? 32'h80000000 : 32'h7FFFFFFF;
          inv = 1'b1;
        end
      end else begin
        m32 = {8'd0, 1'b1, x[22:0]};
        sc = e - 150;
        if (sc >= 0) v = m32 << sc;
        else begin
          v = m32 >> (-sc);
          inx = ((v << (-sc)) != m32);
        end
        r = x[31] ? (~v + 32'd1) : v;
        k = 158 - e;
        cyc = (k + STEP - 1) / STEP + 3;
      end
    end
  endtask

  task automatic applyStimulus(input logic op, input logic [31:0] x, output logic [31:0] out,
                               output logic inv, output logic inx, output int cyc);
    @(negedge clk);
    f_cvt_op = op;
    f_input  = x;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    out = f_output;
    inv = f_invalid;
`ifdef FPCVT_INEXACT_EN
    inx = f_inexact;
`else
    inx = 1'b0;
`endif
  endtask

  task automatic runVector(input string name, input logic op, input logic [31:0] x,
                           input logic [31:0] want, input logic winv, input logic winx, input int wcyc);
    logic [31:0] out;
    logic inv, inx;
    int cyc;
    applyStimulus(op, x, out, inv, inx, cyc);
    checkOutput({name, ".out"}, out, want);
    checkOutput({name, ".invalid"}, {31'd0, inv}, {31'd0, winv});
    checkOutput({name, ".cycle"}, 32'(cyc), 32'(wcyc));
`ifdef FPCVT_INEXACT_EN
    checkOutput({name, ".inexact"}, {31'd0, inx}, {31'd0, winx});
`else
    if (winx === 1'bx) checkOutput({name, ".inexact"}, {31'd0, inx}, 32'd0);
`endif
    @(posedge clk);
    #1;
    checkOutput({name, ".idle_after"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[12];
    logic [31:0] x, r, rnd, out;
    logic inv, inx;
    int cyc, ndone, first, c;

    tbl[0]  = '{"i2f_one",    1'b0, 32'h00000001, 32'h3F800000, 1'b0, 1'b0, 34};
    tbl[1]  = '{"i2f_intmin", 1'b0, 32'h80000000, 32'hCF000000, 1'b0, 1'b0, 3};
    tbl[2]  = '{"i2f_tie",    1'b0, 32'h01FFFFFF, 32'h4C000000, 1'b0, 1'b1, 10};
    tbl[3]  = '{"i2f_zero",   1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 2};
    tbl[4]  = '{"i2f_three",  1'b0, 32'h00000003, 32'h40400000, 1'b0, 1'b0, 33};
    tbl[5]  = '{"f2i_negpi",  1'b1, 32'hC0490FDB, 32'hFFFFFFFD, 1'b0, 1'b1, 33};
    tbl[6]  = '{"f2i_half",   1'b1, 32'h3F000000, 32'h00000000, 1'b0, 1'b1, 2};
    tbl[7]  = '{"f2i_inf",    1'b1, 32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0, 2};
    tbl[8]  = '{"f2i_2p31",   1'b1, 32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0, 2};
    tbl[9]  = '{"f2i_m2p31",  1'b1, 32'hCF000000, 32'h80000000, 1'b0, 1'b0, 2};
    tbl[10] = '{"f2i_1p5",    1'b1, 32'h3FC00000, 32'h00000001, 1'b0, 1'b1, 34};
    tbl[11] = '{"f2i_negsat", 1'b1, 32'hD0000000, 32'h80000000, 1'b1, 1'b0, 2};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.out", f_output, 32'd0);
    checkOutput("reset.flags", {29'd0, busy, done, f_invalid}, 32'd0);
`ifdef FPCVT_INEXACT_EN
    checkOutput("reset.inexact", {31'd0, f_inexact}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      runVector(tbl[i].name, tbl[i].op, tbl[i].in, tbl[i].want, tbl[i].inv, tbl[i].inx, tbl[i].cyc);

    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      x = x >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) x = ~x + 32'd1;
      refModel(1'b0, x, r, inv, inx, cyc);
      runVector($sformatf("rnd_i2f_%0d", i), 1'b0, x, r, inv, inx, cyc);

      rnd = $urandom;
      x = {rnd[31], 8'($urandom_range(118, 162)), rnd[22:0]};
      if (i % 10 == 0) x[30:23] = 8'hFF;
      refModel(1'b1, x, r, inv, inx, cyc);
      runVector($sformatf("rnd_f2i_%0d", i), 1'b1, x, r, inv, inx, cyc);
    end

    // start during SHIFT and during DONE must both be ignored
    @(negedge clk);
    f_cvt_op = 1'b0; f_input = 32'h00000001; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    c = 1; ndone = 0; first = 0; out = '0;
    repeat (50) begin
      if (done === 1'b1) begin
        ndone++;
        if (first == 0) begin
          first = c;
          out = f_output;
        end
      end
      if (c == 5 || (done === 1'b1 && ndone == 1)) begin
        @(negedge clk);
        start = 1'b1; f_cvt_op = 1'b1; f_input = 32'h4F000000;
      end
      @(posedge clk);
      #1 start = 1'b0;
      c++;
      if (first != 0 && c == first + 1) checkOutput("busy_ign.busy_after_done", {31'd0, busy}, 32'd0);
    end
    checkOutput("busy_ign.out", out, 32'h3F800000);
    checkOutput("busy_ign.cycle", 32'(first), 32'd34);
    checkOutput("busy_ign.done_count", 32'(ndone), 32'd1);

    // asynchronous reset in the middle of SHIFT aborts the operation
    @(negedge clk);
    f_cvt_op = 1'b0; f_input = 32'h00000001; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset.out", f_output, 32'd0);
    checkOutput("midreset.flags", {29'd0, busy, done, f_invalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    checkOutput("midreset.no_done", 32'(ndone), 32'd0);
    runVector("after_reset", 1'b1, 32'hC0490FDB, 32'hFFFFFFFD, 1'b0, 1'b1, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
